// File: rtl/activation_scheduler.sv
// Sequences a layer z-vector element by element through a shared activation
// unit and collects the results into a packed activation vector.
module activation_scheduler #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_z,
    output logic [W-1:0]    act_z,
    input  logic [W-1:0]    act_a,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_a,
    output logic            busy,
    output logic [IW-1:0]   idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    state_t            state_reg;
    logic [IW-1:0]     idx_reg;
    logic [N*W-1:0]    z_buf_reg;
    logic [W-1:0]      act_z_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic              busy_reg;
    logic [W-1:0]      z_next;
    logic [N*W-1:0]    a_buf;

    // Element that follows idx_reg, so act_z can be registered one cycle ahead.
    always_comb begin
        z_next = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (idx_reg == IW'(i)) begin
                z_next = z_buf_reg[(i+1)*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            z_buf_reg     <= '0;
            act_z_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        z_buf_reg    <= in_z;
                        idx_reg      <= '0;
                        act_z_reg    <= in_z[W-1:0];
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    if (idx_reg == IDX_LAST) begin
                        idx_reg       <= '0;
                        act_z_reg     <= '0;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        act_z_reg <= z_next;
                    end
                end
                DONE: begin
                    // Leaving DONE always passes through IDLE, so no vector is taken here.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    idx_reg       <= '0;
                    act_z_reg     <= '0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    // One result register per element, captured while that element is issued.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_abuf
            logic [W-1:0] a_elem_reg;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    a_elem_reg <= '0;
                end else if (state_reg == RUN && idx_reg == IW'(gi)) begin
                    a_elem_reg <= act_a;
                end
            end
            assign a_buf[gi*W +: W] = a_elem_reg;
        end
    endgenerate

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign act_z     = act_z_reg;
    assign idx       = idx_reg;
    assign out_a     = a_buf;

endmodule

// File: tb/tb_activation_scheduler.sv
// Randomized bench for activation_scheduler (N=4 and N=1 instances) with a
// shared unit act_a = act_z >>> 1 and a floor(z/2) reference model.
module tb_activation_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_z;
    logic [W-1:0]   act_z;
    logic [W-1:0]   act_a;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_a;
    logic           busy;
    logic [IW-1:0]  idx;

    logic           in_valid1;
    logic           in_ready1;
    logic [W-1:0]   in_z1;
    logic [W-1:0]   act_z1;
    logic [W-1:0]   act_a1;
    logic           out_valid1;
    logic           out_ready1;
    logic [W-1:0]   out_a1;
    logic           busy1;
    logic [0:0]     idx1;

    int checks = 0;
    int errors = 0;

    activation_scheduler #(.N(N), .W(W), .IW(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
        .act_z(act_z), .act_a(act_a), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .busy(busy), .idx(idx)
    );

    activation_scheduler #(.N(1), .W(W), .IW(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_z(in_z1),
        .act_z(act_z1), .act_a(act_a1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_a(out_a1), .busy(busy1), .idx(idx1)
    );

    // Shared activation unit stand-in.
    assign act_a  = $signed(act_z) >>> 1;
    assign act_a1 = $signed(act_z1) >>> 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each element becomes floor(z/2), computed on plain integers.
    function automatic logic [N*W-1:0] model_vec(input logic [N*W-1:0] z);
        logic [N*W-1:0] r;
        logic [W-1:0]   zb;
        logic [31:0]    hv;
        int             v;
        int             h;
        r = '0;
        for (int i = 0; i < N; i++) begin
            zb = z[i*W +: W];
            v  = int'($signed(zb));
            h  = (v < 0) ? -((1 - v) / 2) : v / 2;
            hv = h;
            r[i*W +: W] = hv[W-1:0];
        end
        return r;
    endfunction

    // Enters and leaves at a falling edge with the N=4 instance idle.
    task automatic process_vector(input logic [N*W-1:0] z, input logic [N*W-1:0] exp,
                                  input int hold, input string name);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready: in_ready=%b required 1", name, in_ready);
        end
        in_valid  = 1'b1;
        in_z      = z;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_z      = $urandom();
            out_ready = 1'($urandom_range(0, 1));
            checks++;
            if (act_z !== z[i*W +: W] || idx !== IW'(i) || busy !== 1'b1 ||
                in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s run[%0d]: act_z=%h idx=%0d busy=%b in_ready=%b out_valid=%b required act_z=%h idx=%0d busy=1 in_ready=0 out_valid=0",
                         name, i, act_z, idx, busy, in_ready, out_valid, z[i*W +: W], i);
            end
            @(negedge clk);
        end
        for (int c = 0; c <= hold; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_a !== exp || in_ready !== 1'b0 ||
                busy !== 1'b0 || act_z !== '0) begin
                errors++;
                $display("FAIL %s done[%0d]: out_valid=%b out_a=%h in_ready=%b busy=%b act_z=%h required out_valid=1 out_a=%h in_ready=0 busy=0 act_z=00",
                         name, c, out_valid, out_a, in_ready, busy, act_z, exp);
            end
            in_valid  = 1'b1;
            in_z      = $urandom();
            out_ready = (c == hold);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s back_idle: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     name, out_valid, in_ready, busy);
        end
        $display("vector %s z=%h out_a=%h hold=%0d", name, z, exp, hold);
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b1; in_z = $urandom(); out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || act_z !== 8'h00 ||
                out_a !== '0 || busy !== 1'b0 || idx !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b act_z=%h out_a=%h busy=%b idx=%0d required 1 0 00 0 0 0",
                         c, in_ready, out_valid, act_z, out_a, busy, idx);
            end
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b in_ready=%b out_valid=%b required 0 1 0",
                     busy, in_ready, out_valid);
        end
        $display("reset done");
    endtask

    task automatic test_single_vector;
        process_vector({8'h80, 8'h7F, 8'hF0, 8'h10}, {8'hC0, 8'h3F, 8'hF8, 8'h08}, 0, "directed");
    endtask

    task automatic test_backpressure;
        logic [N*W-1:0] z;
        z = $urandom();
        process_vector(z, model_vec(z), 3, "backpressure");
    endtask

    task automatic test_random;
        logic [N*W-1:0] z;
        for (int k = 0; k < 6; k++) begin
            z = $urandom();
            process_vector(z, model_vec(z), int'($urandom_range(0, 4)), "random");
        end
    endtask

    task automatic test_back_to_back;
        logic [N*W-1:0] q[$];
        logic [N*W-1:0] exp;
        int accepts;
        int outs;
        int last_acc;
        accepts = 0; outs = 0; last_acc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_z = $urandom();
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra_out cycle %0d: out_valid=1 required 0", c);
                end else begin
                    exp = model_vec(q.pop_front());
                    if (out_a !== exp) begin
                        errors++;
                        $display("FAIL stream_out[%0d]: out_a=%h required %h", outs, out_a, exp);
                    end
                    $display("stream out %0d out_a=%h", outs, out_a);
                end
                outs++;
            end
            if (in_ready === 1'b1) begin
                if (accepts > 0) begin
                    checks++;
                    if (c - last_acc != N + 2) begin
                        errors++;
                        $display("FAIL stream_gap: gap=%0d required %0d", c - last_acc, N + 2);
                    end
                end
                q.push_back(in_z);
                last_acc = c;
                accepts++;
                $display("stream accept %0d z=%h cycle %0d", accepts, in_z, c);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (accepts != 5 || outs != 5) begin
            errors++;
            $display("FAIL stream_count: accepts=%0d outputs=%0d required 5 5", accepts, outs);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [N*W-1:0] z;
        int seen;
        in_valid = 1'b1; in_z = $urandom();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_a !== '0 || act_z !== '0 || idx !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b in_ready=%b out_valid=%b out_a=%h act_z=%h idx=%0d required 0 1 0 0 00 0",
                     busy, in_ready, out_valid, out_a, act_z, idx);
        end
        seen = 0;
        for (int c = 0; c < N + 3; c++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: active cycles=%0d required 0", seen);
        end
        $display("mid-run reset done");
        z = $urandom();
        process_vector(z, model_vec(z), 1, "after_reset");
    endtask

    task automatic test_n1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_idle: in_ready=%b required 1", in_ready1);
        end
        in_valid1 = 1'b1; in_z1 = 8'hE0;
        @(negedge clk);
        in_valid1 = 1'b0;
        checks++;
        if (act_z1 !== 8'hE0 || busy1 !== 1'b1 || out_valid1 !== 1'b0 || idx1 !== 1'b0) begin
            errors++;
            $display("FAIL n1_run: act_z=%h busy=%b out_valid=%b idx=%0d required E0 1 0 0",
                     act_z1, busy1, out_valid1, idx1);
        end
        @(negedge clk);
        checks++;
        if (act_z1 !== 8'h00 || busy1 !== 1'b0 || out_valid1 !== 1'b1 || out_a1 !== 8'hF0) begin
            errors++;
            $display("FAIL n1_done: act_z=%h busy=%b out_valid=%b out_a=%h required 00 0 1 F0",
                     act_z1, busy1, out_valid1, out_a1);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL n1_back_idle: out_valid=%b in_ready=%b required 0 1", out_valid1, in_ready1);
        end
        $display("n1 vector z=E0 out_a=%h", out_a1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_z = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_z1 = '0; out_ready1 = 1'b0;
        test_reset();
        test_single_vector();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_n1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
